// File: rtl/shram_arbiter_if.sv
// Signal bundle for shram_arbiter: CPU request port, MCU request port and shared-RAM port.
// slave = arbiter side, master = requesters/RAM side.
interface shram_arbiter_if #(
  parameter int AW = 12
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_ack;

  logic          mcu_cs;
  logic          mcu_we;
  logic [AW-1:0] mcu_addr;
  logic [7:0]    mcu_dout;
  logic [7:0]    mcu_din;
  logic          mcu_ack;
  logic          mcu_wait;
  logic          mcu_int;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_dout,
    output cpu_din, cpu_ack,
    input  mcu_cs, mcu_we, mcu_addr, mcu_dout,
    output mcu_din, mcu_ack, mcu_wait, mcu_int,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_dout,
    input  cpu_din, cpu_ack,
    output mcu_cs, mcu_we, mcu_addr, mcu_dout,
    input  mcu_din, mcu_ack, mcu_wait, mcu_int,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/shram_arbiter.sv
// Shared 4 KB RAM arbiter between main CPU and MCU: IDLE/ACC/DATA sequencing, 1-cycle acks, mailbox IRQ.
// Define SHRAM_CPU_PRIORITY_EN for fixed CPU priority; otherwise ties are resolved round-robin.
module shram_arbiter #(
  parameter int            AW       = 12,
  parameter logic [AW-1:0] INT_ADDR = 12'hFFF
) (
  input  logic           CLK_32M,
  input  logic           reset,
  shram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          grant_mcu_q, grant_mcu_d;
  logic          acc_we_q, acc_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic [7:0]    cpu_din_q, cpu_din_d;
  logic [7:0]    mcu_din_q, mcu_din_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          mcu_ack_q, mcu_ack_d;
  logic          mcu_int_q, mcu_int_d;
  logic          pick_mcu;
`ifndef SHRAM_CPU_PRIORITY_EN
  logic          last_mcu_q, last_mcu_d;
`endif

  // Winner of the IDLE decision; only meaningful when at least one request is present.
  always_comb begin
    pick_mcu = 1'b0;
    if (bus.mcu_cs && !bus.cpu_req) begin
      pick_mcu = 1'b1;
    end else if (bus.mcu_cs && bus.cpu_req) begin
`ifdef SHRAM_CPU_PRIORITY_EN
      pick_mcu = 1'b0;
`else
      pick_mcu = ~last_mcu_q;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_mcu_d = grant_mcu_q;
    acc_we_d    = acc_we_q;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_wdata_d = '0;
    cpu_din_d   = cpu_din_q;
    mcu_din_d   = mcu_din_q;
    cpu_ack_d   = 1'b0;
    mcu_ack_d   = 1'b0;
    mcu_int_d   = mcu_int_q;
`ifndef SHRAM_CPU_PRIORITY_EN
    last_mcu_d  = last_mcu_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.mcu_cs) begin
          state_d     = ACC;
          grant_mcu_d = pick_mcu;
`ifndef SHRAM_CPU_PRIORITY_EN
          last_mcu_d  = pick_mcu;
`endif
          acc_we_d    = pick_mcu ? bus.mcu_we : bus.cpu_we;
          ram_addr_d  = pick_mcu ? bus.mcu_addr : bus.cpu_addr;
          ram_wdata_d = pick_mcu ? bus.mcu_dout : bus.cpu_dout;
          ram_we_d    = acc_we_d;
        end
      end
      ACC: begin
        state_d   = DATA;
        cpu_ack_d = ~grant_mcu_q;
        mcu_ack_d = grant_mcu_q;
        // Mailbox: any MCU touch clears, only a CPU write sets; both land in DATA.
        if (ram_addr_q == INT_ADDR) begin
          if (grant_mcu_q) begin
            mcu_int_d = 1'b0;
          end else if (acc_we_q) begin
            mcu_int_d = 1'b1;
          end
        end
      end
      DATA: begin
        state_d = IDLE;
        if (!acc_we_q) begin
          if (grant_mcu_q) begin
            mcu_din_d = bus.ram_rdata;
          end else begin
            cpu_din_d = bus.ram_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_mcu_q <= 1'b0;
      acc_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_din_q   <= '0;
      mcu_din_q   <= '0;
      cpu_ack_q   <= 1'b0;
      mcu_ack_q   <= 1'b0;
      mcu_int_q   <= 1'b0;
`ifndef SHRAM_CPU_PRIORITY_EN
      last_mcu_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      grant_mcu_q <= grant_mcu_d;
      acc_we_q    <= acc_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_din_q   <= cpu_din_d;
      mcu_din_q   <= mcu_din_d;
      cpu_ack_q   <= cpu_ack_d;
      mcu_ack_q   <= mcu_ack_d;
      mcu_int_q   <= mcu_int_d;
`ifndef SHRAM_CPU_PRIORITY_EN
      last_mcu_q  <= last_mcu_d;
`endif
    end
  end

  // Read data passes straight through in the ack cycle, then the captured copy holds it.
  assign bus.cpu_din   = cpu_din_d;
  assign bus.mcu_din   = mcu_din_d;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.mcu_ack   = mcu_ack_q;
  assign bus.mcu_int   = mcu_int_q;
  assign bus.mcu_wait  = bus.mcu_cs & ~mcu_ack_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_shram_arbiter.sv
// Scoreboard bench for shram_arbiter: transaction-level model predicts grant order, read data,
// mailbox state and RAM writes; a negedge monitor compares every ack and every RAM write strobe.
module tb_shram_arbiter;
  localparam int          AW       = 12;
  localparam logic [11:0] INT_ADDR = 12'hFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #16 clk = ~clk;

  shram_arbiter_if #(.AW(AW)) bus ();
  shram_arbiter #(.AW(AW), .INT_ADDR(INT_ADDR)) dut (.CLK_32M(clk), .reset(rst), .bus(bus));

  // Shared RAM with one-cycle registered read
  logic [7:0] mem [0:4095];
  bit ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      ram_init_done <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        mcu;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  din;
    logic        irq;
  } exp_t;
  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [7:0] shadow [0:4095];
  logic model_int, model_last_mcu;
  logic [7:0] model_cpu_din, model_mcu_din;

  int tests = 0;
  int fails = 0;
  logic solo_mode = 1'b0;
  logic contend_mode = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    model_int      = 1'b0;
    model_last_mcu = 1'b1;
    model_cpu_din  = 8'h00;
    model_mcu_din  = 8'h00;
  endtask

  // One granted access, applied in grant order
  task automatic model_access(input logic mcu, input logic we, input logic [11:0] a, input logic [7:0] d);
    exp_t e;
    wr_t  w;
    if (we) begin
      shadow[a] = d;
      w.addr = a;
      w.data = d;
      wr_q.push_back(w);
    end else if (mcu) begin
      model_mcu_din = shadow[a];
    end else begin
      model_cpu_din = shadow[a];
    end
    if (a == INT_ADDR) begin
      if (mcu) model_int = 1'b0;
      else if (we) model_int = 1'b1;
    end
    model_last_mcu = mcu;
    e.mcu  = mcu;
    e.we   = we;
    e.addr = a;
    e.din  = mcu ? model_mcu_din : model_cpu_din;
    e.irq  = model_int;
    exp_q.push_back(e);
  endtask

  function automatic logic model_tie_mcu();
`ifdef SHRAM_CPU_PRIORITY_EN
    return 1'b0;
`else
    return ~model_last_mcu;
`endif
  endfunction

  function automatic logic [11:0] rnd_addr();
    case ($urandom_range(0, 3))
      0: return 12'h123;
      1: return INT_ADDR;
      2: return 12'($urandom_range(0, 15));
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic wait_ack(input logic mcu);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mcu ? bus.mcu_ack : bus.cpu_ack) && n < 30);
    check(mcu ? "mcu_ack_timeout" : "cpu_ack_timeout", int'(n < 30), 1);
  endtask

  task automatic cpu_drive(input logic we, input logic [11:0] a, input logic [7:0] d);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    wait_ack(1'b0);
    @(posedge clk); #1;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'($urandom);
    bus.cpu_addr = 12'($urandom);
    bus.cpu_dout = 8'($urandom);
  endtask

  task automatic mcu_drive(input logic we, input logic [11:0] a, input logic [7:0] d);
    bus.mcu_cs   = 1'b1;
    bus.mcu_we   = we;
    bus.mcu_addr = a;
    bus.mcu_dout = d;
    wait_ack(1'b1);
    @(posedge clk); #1;
    bus.mcu_cs   = 1'b0;
    bus.mcu_we   = 1'($urandom);
    bus.mcu_addr = 12'($urandom);
    bus.mcu_dout = 8'($urandom);
  endtask

  task automatic solo(input logic mcu, input logic we, input logic [11:0] a, input logic [7:0] d);
    model_access(mcu, we, a, d);
    @(posedge clk); #1;
    solo_mode = 1'b1;
    if (mcu) mcu_drive(we, a, d);
    else cpu_drive(we, a, d);
    solo_mode = 1'b0;
  endtask

  logic        cw [0:7];
  logic [11:0] ca [0:7];
  logic [7:0]  cd [0:7];
  logic        mw [0:7];
  logic [11:0] ma [0:7];
  logic [7:0]  md [0:7];

  // Both raise together; each drops for one cycle after its ack, so grants alternate after the tie.
  task automatic contend_block(input int n);
    logic first_mcu;
    logic who;
    for (int k = 0; k < n; k++) begin
      cw[k] = 1'($urandom); ca[k] = rnd_addr(); cd[k] = 8'($urandom);
      mw[k] = 1'($urandom); ma[k] = rnd_addr(); md[k] = 8'($urandom);
    end
    first_mcu = model_tie_mcu();
    for (int k = 0; k < 2 * n; k++) begin
      who = first_mcu ^ k[0];
      if (who) model_access(1'b1, mw[k / 2], ma[k / 2], md[k / 2]);
      else model_access(1'b0, cw[k / 2], ca[k / 2], cd[k / 2]);
    end
    @(posedge clk); #1;
    contend_mode = 1'b1;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          cpu_drive(cw[k], ca[k], cd[k]);
        end
      end
      begin
        for (int k = 0; k < n; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          mcu_drive(mw[k], ma[k], md[k]);
        end
      end
    join
    contend_mode = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t mon_e;
    wr_t  mon_w;
    logic cpu_req_prev = 1'b0, mcu_cs_prev = 1'b0, ram_we_prev = 1'b0, have_prev = 1'b0;
    int   cpu_start = 0, mcu_start = 0, last_ack = 0;
    forever begin
      @(negedge clk);
      if (bus.cpu_req && !cpu_req_prev) cpu_start = cyc;
      if (bus.mcu_cs && !mcu_cs_prev) mcu_start = cyc;
      if (!contend_mode) have_prev = 1'b0;
      if (!rst) begin
        if (bus.mcu_ack) check("mcu_wait_at_ack", int'(bus.mcu_wait), 0);
        else check("mcu_wait", int'(bus.mcu_wait), int'(bus.mcu_cs));
      end
      if (bus.cpu_ack && bus.mcu_ack) begin
        check("dual_ack", 1, 0);
      end else if (bus.cpu_ack || bus.mcu_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", int'({bus.cpu_ack, bus.mcu_ack}), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_owner", int'(bus.mcu_ack), int'(mon_e.mcu));
          if (mon_e.mcu) check("mcu_din", int'(bus.mcu_din), int'(mon_e.din));
          else check("cpu_din", int'(bus.cpu_din), int'(mon_e.din));
          check("mcu_int", int'(bus.mcu_int), int'(mon_e.irq));
          if (solo_mode) check("ack_latency", cyc - (mon_e.mcu ? mcu_start : cpu_start), 2);
          if (contend_mode && have_prev) check("grant_spacing", cyc - last_ack, 3);
          $display("[TB] cyc %0d %s %s addr=0x%03h din=0x%02h irq=%0d", cyc, mon_e.mcu ? "MCU" : "CPU",
                   mon_e.we ? "WR" : "RD", mon_e.addr, mon_e.mcu ? bus.mcu_din : bus.cpu_din, bus.mcu_int);
        end
        last_ack  = cyc;
        have_prev = contend_mode;
      end
      if (bus.ram_we) begin
        check("ram_we_pulse", int'(ram_we_prev), 0);
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_w = wr_q.pop_front();
          check("ram_addr", int'(bus.ram_addr), int'(mon_w.addr));
          check("ram_wdata", int'(bus.ram_wdata), int'(mon_w.data));
        end
      end
      ram_we_prev  = bus.ram_we;
      cpu_req_prev = bus.cpu_req;
      mcu_cs_prev  = bus.mcu_cs;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
    model_reset();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_dout = '0;
    bus.mcu_cs  = 1'b0; bus.mcu_we = 1'b0; bus.mcu_addr = '0; bus.mcu_dout = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_din", int'({bus.cpu_din, bus.mcu_din}), 0);
    check("rst_ram", int'({bus.ram_addr, bus.ram_wdata, bus.ram_we}), 0);
    check("rst_flags", int'({bus.cpu_ack, bus.mcu_ack, bus.mcu_int, bus.mcu_wait}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    solo(1'b0, 1'b1, 12'h123, 8'h5A);
    solo(1'b1, 1'b0, 12'h123, 8'h00);

    contend_block(4);

    solo(1'b0, 1'b1, INT_ADDR, 8'h01);
    solo(1'b0, 1'b0, INT_ADDR, 8'h00);
    solo(1'b1, 1'b0, INT_ADDR, 8'h00);

    for (int i = 0; i < 40; i++) solo(1'($urandom), 1'($urandom), rnd_addr(), 8'($urandom));
    for (int i = 0; i < 3; i++) contend_block(3);

    // Reset during ACC of a CPU write: the RAM strobe was already out, but no ack follows
    solo(1'b0, 1'b1, INT_ADDR, 8'h33);
    begin
      wr_t w;
      w.addr = 12'h0AA;
      w.data = 8'h77;
      wr_q.push_back(w);
      shadow[12'h0AA] = 8'h77;
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h0AA; bus.cpu_dout = 8'h77;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rst_abort_ram_we", int'(bus.ram_we), 0);
    check("rst_abort_cpu_ack", int'(bus.cpu_ack), 0);
    check("rst_abort_mcu_int", int'(bus.mcu_int), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    contend_block(2);

`ifdef SHRAM_CPU_PRIORITY_EN
    // CPU holds its request across three accesses while the MCU waits
    for (int k = 0; k < 3; k++) model_access(1'b0, 1'b1, 12'(12'h200 + k), 8'(8'hC0 + k));
    model_access(1'b1, 1'b0, 12'h200, 8'h00);
    @(posedge clk); #1;
    contend_mode = 1'b1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
          bus.cpu_addr = 12'(12'h200 + k); bus.cpu_dout = 8'(8'hC0 + k);
          wait_ack(1'b0);
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
      end
      mcu_drive(1'b0, 12'h200, 8'h00);
    join
    contend_mode = 1'b0;
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("exp_drained", exp_q.size(), 0);
    check("wr_drained", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
